// File: rtl/btn_pkg.sv
// Shared types and helpers for the button toggle control slice.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } btn_state_e;

    function automatic int ms_to_cycles(input int freq, input int ms);
        return (freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: polarity fix, 2-flop synchroniser and debounce counter.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DB_CYCLES      = 4,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pressed
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            btn_n;
    logic            sync1_q;
    logic            btn_s_q;
    logic            pressed_q, pressed_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    assign btn_n = btn_raw ^ BTN_ACTIVE_LOW;

    // The counter only survives while the synchronised level keeps disagreeing.
    always_comb begin
        pressed_d = pressed_q;
        db_cnt_d  = '0;
        if (btn_s_q != pressed_q) begin
            if (db_cnt_q == DB_LAST) begin
                pressed_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            btn_s_q   <= 1'b0;
            pressed_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= btn_n;
            btn_s_q   <= sync1_q;
            pressed_q <= pressed_d;
            db_cnt_q  <= db_cnt_d;
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/btn_toggle_ctrl.sv
// Blink-counter enable control: short press toggles enable, long press clears it.
module btn_toggle_ctrl
    import btn_pkg::*;
#(
    parameter int FREQ           = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic enable,
    output logic pressed,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int DB_CYCLES   = ms_to_cycles(FREQ, DEBOUNCE_MS);
    localparam int LONG_CYCLES = ms_to_cycles(FREQ, LONG_MS);
    localparam int HOLD_W      = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] LONG_HIT = HOLD_W'(LONG_CYCLES - 1);

    btn_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_inc;
    logic              enable_q, enable_d;
    logic              short_pulse_q, short_pulse_d;
    logic              long_pulse_q, long_pulse_d;
    logic              pressed_prev_q;
    logic              press_edge;
    logic              release_edge;

    btn_debounce #(
        .DB_CYCLES     (DB_CYCLES),
        .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .pressed(pressed)
    );

    assign press_edge   = pressed & ~pressed_prev_q;
    assign release_edge = ~pressed & pressed_prev_q;
    assign hold_inc     = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);

    // Long threshold is judged on the value the hold counter is about to take.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        enable_d      = enable_q;
        short_pulse_d = 1'b0;
        long_pulse_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_edge) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                end
            end
            HELD: begin
                hold_cnt_d = hold_inc;
                if (release_edge) begin
                    short_pulse_d = 1'b1;
                    enable_d      = ~enable_q;
                    state_d       = IDLE;
                end else if (pressed && (hold_inc == LONG_HIT)) begin
                    long_pulse_d = 1'b1;
                    enable_d     = 1'b0;
                    state_d      = LONG;
                end
            end
            LONG: begin
                if (release_edge) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            hold_cnt_q     <= '0;
            enable_q       <= 1'b0;
            short_pulse_q  <= 1'b0;
            long_pulse_q   <= 1'b0;
            pressed_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            enable_q       <= enable_d;
            short_pulse_q  <= short_pulse_d;
            long_pulse_q   <= long_pulse_d;
            pressed_prev_q <= pressed;
        end
    end

    assign enable      = enable_q;
    assign short_pulse = short_pulse_q;
    assign long_pulse  = long_pulse_q;

endmodule

// File: tb/tb_btn_toggle_ctrl.sv
// Scoreboard bench for btn_toggle_ctrl: active-low and active-high instances against one press-level model.
module tb_btn_toggle_ctrl;

    localparam int FREQ        = 1000;
    localparam int DEBOUNCE_MS = 4;
    localparam int LONG_MS     = 20;
    localparam int DB          = FREQ / 1000 * DEBOUNCE_MS;
    localparam int LONGC       = FREQ / 1000 * LONG_MS;

    typedef struct {
        int cyc;
        bit is_long;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       press = 1'b0;
    logic       stim_done = 1'b0;
    logic       btn_raw_lo, btn_raw_hi;
    logic [1:0] enable_w, pressed_w, short_w, long_w;

    assign btn_raw_lo = ~press;
    assign btn_raw_hi = press;

    always #5 clk = ~clk;

    btn_toggle_ctrl #(
        .FREQ(FREQ), .DEBOUNCE_MS(DEBOUNCE_MS), .LONG_MS(LONG_MS), .BTN_ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk(clk), .rst(rst), .btn_raw(btn_raw_lo), .enable(enable_w[0]),
        .pressed(pressed_w[0]), .short_pulse(short_w[0]), .long_pulse(long_w[0])
    );

    btn_toggle_ctrl #(
        .FREQ(FREQ), .DEBOUNCE_MS(DEBOUNCE_MS), .LONG_MS(LONG_MS), .BTN_ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk(clk), .rst(rst), .btn_raw(btn_raw_hi), .enable(enable_w[1]),
        .pressed(pressed_w[1]), .short_pulse(short_w[1]), .long_pulse(long_w[1])
    );

    // Reference: the press level arrives two edges late; pressed flips once that delayed
    // level has disagreed for DB edges in a row. A press lasting fewer than LONGC edges
    // is short (pulse the edge after release), otherwise long (pulse LONGC edges after rise).
    int   cyc = 0;
    bit   m_d1 = 1'b0, m_d2 = 1'b0;
    bit   m_pressed = 1'b0;
    bit   m_en = 1'b0;
    int   m_run = 0;
    int   rise_at = -1;
    int   fall_at = -1;
    evt_t q0[$];
    evt_t q1[$];

    always @(posedge clk) begin
        evt_t ev;
        cyc = cyc + 1;
        if (rst) begin
            m_d1 = 1'b0; m_d2 = 1'b0; m_pressed = 1'b0; m_en = 1'b0;
            m_run = 0; rise_at = -1; fall_at = -1;
        end else begin
            if (m_pressed && rise_at >= 0 && (cyc - rise_at) == LONGC) begin
                m_en = 1'b0;
                ev.cyc = cyc; ev.is_long = 1'b1;
                q0.push_back(ev); q1.push_back(ev);
            end
            if (!m_pressed && fall_at >= 0 && cyc == fall_at + 1 && (fall_at - rise_at) < LONGC) begin
                m_en = ~m_en;
                ev.cyc = cyc; ev.is_long = 1'b0;
                q0.push_back(ev); q1.push_back(ev);
            end
            if (m_d2 != m_pressed) begin
                m_run = m_run + 1;
                if (m_run == DB) begin
                    m_pressed = m_d2;
                    m_run = 0;
                    if (m_pressed) rise_at = cyc;
                    else fall_at = cyc;
                end
            end else begin
                m_run = 0;
            end
            m_d2 = m_d1;
            m_d1 = press;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic report(input int idx, input string what, input int act, input int req);
        n_fail++;
        $display("FAIL dut%0d %s at cycle %0d: actual %0d, required %0d", idx, what, cyc, act, req);
    endtask

    task automatic check_dut(input int idx, input logic p, input logic e, input logic s, input logic l);
        evt_t ev;
        bit   have;
        bit   got_pulse;
        got_pulse = (s === 1'b1) || (l === 1'b1);
        n_tests++;
        if (p !== m_pressed) report(idx, "pressed", int'(p), int'(m_pressed));
        n_tests++;
        if (e !== m_en) report(idx, "enable", int'(e), int'(m_en));
        have = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
        ev.cyc = -1; ev.is_long = 1'b0;
        if (have) begin
            if (idx == 0) ev = q0[0];
            else ev = q1[0];
        end
        if (got_pulse) begin
            n_tests++;
            if (!have) begin
                report(idx, "unexpected_pulse", int'({s, l}), 0);
            end else begin
                if (idx == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                if (ev.cyc != cyc)
                    report(idx, "pulse_cycle", cyc, ev.cyc);
                else if (l !== ev.is_long || s !== !ev.is_long)
                    report(idx, "pulse_kind{short,long}", int'({s, l}), ev.is_long ? 1 : 2);
            end
        end else if (have && ev.cyc <= cyc) begin
            n_tests++;
            report(idx, "missing_pulse", 0, ev.cyc);
            if (idx == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, pressed_w[0], enable_w[0], short_w[0], long_w[0]);
        check_dut(1, pressed_w[1], enable_w[1], short_w[1], long_w[1]);
        if (stim_done) begin
            n_tests++;
            if (q0.size() != 0) report(0, "pulses_outstanding", 0, q0.size());
            n_tests++;
            if (q1.size() != 0) report(1, "pulses_outstanding", 0, q1.size());
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    task automatic hold(input int n);
        press = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        press = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        press = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(50);

        hold(3); idle(10);
        for (int i = 0; i < 12; i++) begin
            press = ~press;
            @(negedge clk);
        end
        idle(10);

        hold(10); idle(20);
        hold(10); idle(20);

        hold(10); idle(20);
        hold(40); idle(20);
        hold(40); idle(20);

        hold(12);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(10); idle(20);

        for (int i = 0; i < 60; i++) begin
            press = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 30)) @(negedge clk);
            if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        idle(40);
        stim_done = 1'b1;
    end

endmodule

// File: doc/btn_toggle_ctrl.md
Name: btn_toggle_ctrl

Overview:
Front-end control stage that produces the enable level for the 1 s LED blink counter. It synchronises and debounces a raw push-button and classifies each press as short or long. A short press toggles enable; a long press forces enable low. One-cycle event pulses and the debounced level are also exported for status LEDs.

Parameters:
FREQ, 50_000_000, clk frequency in Hz
DEBOUNCE_MS, 20, required stable time before the debounced level changes; DB_CYCLES = FREQ/1000*DEBOUNCE_MS (must be >= 1)
LONG_MS, 1000, hold time that classifies a press as long; LONG_CYCLES = FREQ/1000*LONG_MS (must be > DB_CYCLES)
BTN_ACTIVE_LOW, 1, 1 = btn_raw is low when pressed; 0 = high when pressed

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
btn_raw  input  1  asynchronous button pin
enable  output  1  registered run-enable level for the blink counter
pressed  output  1  debounced button level, 1 = pressed
short_pulse  output  1  one-cycle pulse on release of a short press
long_pulse  output  1  one-cycle pulse when the long threshold is reached

Behaviour:
- Polarity: btn_n = btn_raw XOR BTN_ACTIVE_LOW, so 1 means pressed. It feeds a 2-flop synchroniser whose output is btn_s.
- Debounce: counter db_cnt has width $clog2(DB_CYCLES+1). On each edge where btn_s != pressed: if db_cnt == DB_CYCLES-1, then pressed <= btn_s and db_cnt <= 0; otherwise db_cnt++. If btn_s == pressed, db_cnt <= 0.
- Debounce latency: pressed changes exactly DB_CYCLES+2 edges after btn_raw settles. Any bounce shorter than DB_CYCLES cycles leaves no trace.
- Press edge = pressed rises; release edge = pressed falls. Both are detected from the registered previous value.
- FSM states: IDLE, HELD, LONG.
  - IDLE: on press edge, go to HELD and clear hold_cnt.
  - HELD: hold_cnt increments once per cycle.
    - If hold_cnt reaches LONG_CYCLES-1 while pressed, assert long_pulse, set enable <= 0, go to LONG.
    - On release edge, assert short_pulse, set enable <= ~enable, go to IDLE.
  - LONG: on release edge, go to IDLE. No pulse is generated.
- hold_cnt saturates and never wraps. Its width is $clog2(LONG_CYCLES+1).
- Press and release edges cannot occur in the same cycle (pressed is a single register).
- Pulses are registered and high for exactly one cycle, in the cycle after the deciding edge. short_pulse and long_pulse are never high together.
- enable changes in the same cycle its pulse is high.
- Reset: sync flops, pressed, enable, short_pulse, long_pulse, db_cnt and hold_cnt all go to 0; FSM goes to IDLE.
- Reset mid-press: state is discarded. A button still held after rst deasserts is treated as a new press, with debounce restarting from the released level.

Decomposition:
- Shared package btn_pkg:
  - FSM state encodings (IDLE/HELD/LONG, 2 bits)
  - function ms_to_cycles(freq, ms) for DB_CYCLES and LONG_CYCLES
- Sub-module btn_debounce: polarity, 2-flop sync and debounce counter; outputs the pressed level.
- The FSM, hold counter and enable register stay in btn_toggle_ctrl.

Test Plan:
All scenarios use FREQ=1000, DEBOUNCE_MS=4, LONG_MS=20, which gives DB_CYCLES=4 and LONG_CYCLES=20.
1. Reset: hold rst for 3 cycles with btn_raw idle -> all outputs 0; outputs stay 0 for 50 idle cycles.
2. Glitch: drive btn_raw active for 3 cycles, then idle (also test repeated 1-cycle bounces) -> pressed never rises, no pulses.
3. Short press: press held 10 cycles -> pressed rises 6 edges after the change. On release, short_pulse is high 1 cycle, enable goes 0->1. A second short press -> enable 1->0.
4. Long press with enable=1: hold 40 cycles -> long_pulse once, 20 cycles after pressed rises; enable -> 0; release gives no short_pulse. A second long press with enable=0 leaves enable at 0.
5. Reset mid-press: assert rst in HELD while the button stays pressed -> outputs 0. Then pressed rises 6 edges after rst deasserts, and release yields short_pulse.
6. Polarity: BTN_ACTIVE_LOW=0 instance with an active-high stimulus -> same timing as scenario 3.
